// File: rtl/segway_math_pkg.sv
// Shared constants and helpers for the segway torque math pipeline.
// Consumers: segway_math_slew (top) and segway_slew_lim (per-wheel slew register).
package segway_math_pkg;

    localparam int unsigned DEF_W               = 12;
    localparam logic [12:0] DEF_MIN_DUTY        = 13'h3C0;
    localparam logic [7:0]  DEF_LOW_TORQUE_BAND = 8'h3C;
    localparam logic [5:0]  DEF_GAIN_MULT       = 6'h10;
    localparam logic [11:0] DEF_SLEW_MAX        = 12'h040;
    localparam int          DEF_FAST_THRESH     = 1792;
    localparam int unsigned DEF_FAST_CNT        = 4;

    // Clamp v into the signed range of a w-bit value (w <= 32).
    function automatic logic signed [31:0] sat_s(input logic signed [31:0] v, input int unsigned w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int unsigned steer_clip_lo(input int unsigned w);
        return 32'd1 << (w - 3);
    endfunction

    function automatic int unsigned steer_clip_hi(input int unsigned w);
        return 32'd7 << (w - 3);
    endfunction

endpackage

// File: rtl/segway_slew_lim.sv
// Per-wheel output register with rate limiting toward a target value.
// SEGWAY_MATH_SLEW_EN defined: step-limited approach; undefined: loads target directly.
module segway_slew_lim
    import segway_math_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                vld,
    input  logic                clr,
    input  logic [W-1:0]        step,
    input  logic signed [W-1:0] tgt,
    output logic signed [W-1:0] cur
);

    logic signed [W-1:0] nxt;

`ifdef SEGWAY_MATH_SLEW_EN
    logic signed [W:0] diff;
    logic signed [W:0] mag;
    logic signed [W:0] step_x;

    always_comb begin
        diff   = (W+1)'(tgt) - (W+1)'(cur);
        mag    = diff[W] ? -diff : diff;
        step_x = $signed({1'b0, step});
        if (mag <= step_x)
            nxt = tgt;
        else if (diff[W])
            nxt = cur - $signed(step);
        else
            nxt = cur + $signed(step);
    end
`else
    logic unused_step;
    assign unused_step = ^step;

    always_comb begin
        nxt = tgt;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cur <= '0;
        else if (clr)
            cur <= '0;
        else if (vld)
            cur <= nxt;
    end

endmodule

// File: rtl/segway_math_slew.sv
// Segway torque math: 3-stage valid pipeline (scale/steer, mix, shape+saturate),
// per-wheel slew-limited outputs and debounced too_fast. Option: SEGWAY_MATH_SLEW_EN.
module segway_math_slew
    import segway_math_pkg::*;
#(
    parameter int unsigned W               = DEF_W,
    parameter logic [W:0]  MIN_DUTY        = DEF_MIN_DUTY,
    parameter logic [7:0]  LOW_TORQUE_BAND = DEF_LOW_TORQUE_BAND,
    parameter logic [5:0]  GAIN_MULT       = DEF_GAIN_MULT,
    parameter logic [W-1:0] SLEW_MAX       = DEF_SLEW_MAX,
    parameter int          FAST_THRESH     = DEF_FAST_THRESH,
    parameter int unsigned FAST_CNT        = DEF_FAST_CNT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                vld_in,
    input  logic [W-1:0]        PID_cntrl,
    input  logic [7:0]          ss_tmr,
    input  logic [W-1:0]        steer_pot,
    input  logic                en_steer,
    input  logic                pwr_up,
    output logic                vld_out,
    output logic signed [W-1:0] lft_spd,
    output logic signed [W-1:0] rght_spd,
    output logic                too_fast
);

    localparam logic [W-1:0]          CLIP_LO   = W'(steer_clip_lo(W));
    localparam logic [W-1:0]          CLIP_HI   = W'(steer_clip_hi(W));
    localparam logic signed [W:0]     STEER_MID = (W+1)'((32'd1 << (W - 1)) - 32'd1);
    localparam logic signed [W+7:0]   BAND_X    = (W+8)'(LOW_TORQUE_BAND);
    localparam logic signed [W+7:0]   DUTY_X    = (W+8)'(MIN_DUTY);
    localparam logic signed [W+7:0]   GAIN_X    = (W+8)'(GAIN_MULT);
    localparam int unsigned           CW        = $clog2(FAST_CNT + 1);
    localparam logic [CW-1:0]         CNT_MAX   = CW'(FAST_CNT);

    logic                v1, v2, v3;
    logic signed [W:0]   pid_ss_r;
    logic signed [W+1:0] steer_term_r;
    logic                en_steer_r;
    logic signed [W+1:0] lft_t_r, rght_t_r;
    logic signed [W-1:0] lft_tgt_r, rght_tgt_r;
    logic [CW-1:0]       fast_cnt;

    logic signed [W+8:0] prod;
    logic [W-1:0]        steer_clip;
    logic signed [W:0]   steer_off, steer_sh;
    logic signed [W+1:0] steer_sx, steer_term, steer_use, pid_ext;
    logic                fast_hit;
    logic [CW-1:0]       fast_cnt_nx;

    // Dead-zone offset above the band, gain below it, then clamp to W bits.
    function automatic logic signed [W-1:0] shape(input logic signed [W+1:0] t);
        logic signed [W+7:0] tw, mag, res;
        tw  = (W+8)'(t);
        mag = tw[W+7] ? -tw : tw;
        if (mag > BAND_X)
            res = tw[W+7] ? tw - DUTY_X : tw + DUTY_X;
        else
            res = tw * GAIN_X;
        return W'(sat_s(32'(res), W));
    endfunction

    always_comb begin
        prod = (W+9)'($signed(PID_cntrl)) * (W+9)'($signed({1'b0, ss_tmr}));
        if (steer_pot < CLIP_LO)
            steer_clip = CLIP_LO;
        else if (steer_pot > CLIP_HI)
            steer_clip = CLIP_HI;
        else
            steer_clip = steer_pot;
        steer_off  = $signed({1'b0, steer_clip}) - STEER_MID;
        steer_sh   = steer_off >>> 4;
        steer_sx   = {steer_sh[W], steer_sh};
        steer_term = steer_sx + (steer_sx <<< 1);
        pid_ext    = {pid_ss_r[W], pid_ss_r};
        steer_use  = en_steer_r ? steer_term_r : '0;
        fast_hit   = (int'(lft_tgt_r) > FAST_THRESH) || (int'(rght_tgt_r) > FAST_THRESH);
        if (!fast_hit)
            fast_cnt_nx = '0;
        else if (fast_cnt == CNT_MAX)
            fast_cnt_nx = fast_cnt;
        else
            fast_cnt_nx = fast_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {v1, v2, v3, vld_out} <= '0;
            pid_ss_r     <= '0;
            steer_term_r <= '0;
            en_steer_r   <= 1'b0;
            lft_t_r      <= '0;
            rght_t_r     <= '0;
            lft_tgt_r    <= '0;
            rght_tgt_r   <= '0;
            fast_cnt     <= '0;
            too_fast     <= 1'b0;
        end else if (!pwr_up) begin
            {v1, v2, v3, vld_out} <= '0;
            lft_tgt_r  <= '0;
            rght_tgt_r <= '0;
            fast_cnt   <= '0;
            too_fast   <= 1'b0;
        end else begin
            v1      <= vld_in;
            v2      <= v1;
            v3      <= v2;
            vld_out <= v3;
            if (vld_in) begin
                pid_ss_r     <= prod[W+8:8];
                steer_term_r <= steer_term;
                en_steer_r   <= en_steer;
            end
            if (v1) begin
                lft_t_r  <= pid_ext + steer_use;
                rght_t_r <= pid_ext - steer_use;
            end
            if (v2) begin
                lft_tgt_r  <= shape(lft_t_r);
                rght_tgt_r <= shape(rght_t_r);
            end
            if (v3) begin
                fast_cnt <= fast_cnt_nx;
                too_fast <= (fast_cnt_nx == CNT_MAX);
            end
        end
    end

    // Slew registers clear directly on pwr_up low, bypassing the rate limit.
    segway_slew_lim #(.W(W)) u_slew_lft (
        .clk   (clk),
        .rst_n (rst_n),
        .vld   (v3),
        .clr   (~pwr_up),
        .step  (SLEW_MAX),
        .tgt   (lft_tgt_r),
        .cur   (lft_spd)
    );

    segway_slew_lim #(.W(W)) u_slew_rght (
        .clk   (clk),
        .rst_n (rst_n),
        .vld   (v3),
        .clr   (~pwr_up),
        .step  (SLEW_MAX),
        .tgt   (rght_tgt_r),
        .cur   (rght_spd)
    );

endmodule

// File: tb/tb_segway_math_slew.sv
// Scoreboard bench for segway_math_slew; expectations follow SEGWAY_MATH_SLEW_EN.
module tb_segway_math_slew;

    localparam int SLEW = 64;
    localparam int THR  = 1792;
    localparam int FCNT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld_in = 1'b0;
    logic [11:0] PID_cntrl = '0;
    logic [7:0]  ss_tmr = '0;
    logic [11:0] steer_pot = 12'h800;
    logic        en_steer = 1'b0;
    logic        pwr_up = 1'b1;
    logic        vld_out;
    logic [11:0] lft_spd;
    logic [11:0] rght_spd;
    logic        too_fast;

    typedef struct {
        int l;
        int r;
        int tf;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_fail = 0;
    int   m_l = 0;
    int   m_r = 0;
    int   m_cnt = 0;

    always #5 clk = ~clk;

    segway_math_slew #(.W(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vld_in    (vld_in),
        .PID_cntrl (PID_cntrl),
        .ss_tmr    (ss_tmr),
        .steer_pot (steer_pot),
        .en_steer  (en_steer),
        .pwr_up    (pwr_up),
        .vld_out   (vld_out),
        .lft_spd   (lft_spd),
        .rght_spd  (rght_spd),
        .too_fast  (too_fast)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int slew(input int cur, input int tgt);
`ifdef SEGWAY_MATH_SLEW_EN
        int d;
        d = tgt - cur;
        if (d <= SLEW && d >= -SLEW) return tgt;
        return (d > 0) ? cur + SLEW : cur - SLEW;
`else
        return tgt + 0 * cur;
`endif
    endfunction

    always @(negedge clk) begin
        if (vld_out) begin
            if (q.size() == 0) begin
                chk("unexpected_vld_out", int'(vld_out), 0);
            end else begin
                mon_e = q.pop_front();
                chk("lft_spd", int'($signed(lft_spd)), mon_e.l);
                chk("rght_spd", int'($signed(rght_spd)), mon_e.r);
                chk("too_fast", int'(too_fast), mon_e.tf);
            end
        end
    end

    // tl/tr are the hand-computed pre-slew targets for this input vector.
    task automatic send(input logic [11:0] pid, input logic [7:0] ss, input logic [11:0] sp,
                        input logic en, input int tl, input int tr);
        exp_t e;
        @(negedge clk);
        PID_cntrl = pid;
        ss_tmr    = ss;
        steer_pot = sp;
        en_steer  = en;
        vld_in    = 1'b1;
        m_l = slew(m_l, tl);
        m_r = slew(m_r, tr);
        if (tl > THR || tr > THR)
            m_cnt = (m_cnt < FCNT) ? m_cnt + 1 : m_cnt;
        else
            m_cnt = 0;
        e.l  = m_l;
        e.r  = m_r;
        e.tf = (m_cnt == FCNT) ? 1 : 0;
        q.push_back(e);
    endtask

    task automatic burst(input int n, input logic [11:0] pid, input logic [7:0] ss,
                         input logic [11:0] sp, input logic en, input int tl, input int tr);
        for (int i = 0; i < n; i++) send(pid, ss, sp, en, tl, tr);
        @(negedge clk);
        vld_in = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk("drain_pending", q.size(), 0);
    endtask

    task automatic send_lat(input logic [11:0] pid, input logic [7:0] ss, input logic [11:0] sp,
                            input logic en, input int tl, input int tr);
        int lat;
        bit found;
        send(pid, ss, sp, en, tl, tr);
        lat = 0;
        found = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) vld_in = 1'b0;
            if (vld_out) begin
                found = 1;
                break;
            end
        end
        chk("latency_negedges", found ? lat : -1, 4);
    endtask

    // One in-flight sample plus one sample coincident with pwr_up low; neither may emerge.
    task automatic pwr_pulse();
        @(negedge clk);
        vld_in = 1'b1;
        @(negedge clk);
        pwr_up = 1'b0;
        @(negedge clk);
        pwr_up = 1'b1;
        vld_in = 1'b0;
        chk("pwr_lft_zero", int'($signed(lft_spd)), 0);
        chk("pwr_rght_zero", int'($signed(rght_spd)), 0);
        chk("pwr_too_fast", int'(too_fast), 0);
        chk("pwr_vld_out", int'(vld_out), 0);
        m_l = 0;
        m_r = 0;
        m_cnt = 0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_lft", int'($signed(lft_spd)), 0);
        chk("rst_rght", int'($signed(rght_spd)), 0);
        chk("rst_vld_out", int'(vld_out), 0);
        chk("rst_too_fast", int'(too_fast), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Ramp toward 0x4BF (1215): 19 samples reach it with slew, 1 without.
        send_lat(12'h100, 8'hFF, 12'h800, 1'b0, 1215, 1215);
        drain();
        burst(18, 12'h100, 8'hFF, 12'h800, 1'b0, 1215, 1215);
        drain();
        chk("ramp_end_lft", int'($signed(lft_spd)), 1215);
        chk("ramp_end_rght", int'($signed(rght_spd)), 1215);

        pwr_pulse();

        burst(8,  12'h020, 8'hFF, 12'h800, 1'b0, 496, 496);
        burst(28, 12'h000, 8'hFF, 12'hFFF, 1'b1, 1248, -1248);
        burst(20, 12'h000, 8'hFF, 12'hFFF, 1'b0, 0, 0);
        burst(4,  12'h000, 8'hFF, 12'h000, 1'b1, -1248, 1248);
        burst(25, 12'h03D, 8'hFF, 12'h800, 1'b0, 960, 960);
        burst(3,  12'h03E, 8'hFF, 12'h800, 1'b0, 1021, 1021);
        burst(40, 12'hF00, 8'hFF, 12'h800, 1'b0, -1215, -1215);
        burst(40, 12'h100, 8'h80, 12'h800, 1'b0, 1088, 1088);
        drain();

        burst(6, 12'h7FF, 8'hFF, 12'h800, 1'b0, 2047, 2047);
        drain();
        chk("too_fast_set", int'(too_fast), 1);
        burst(1, 12'h000, 8'hFF, 12'h800, 1'b0, 0, 0);
        drain();
        chk("too_fast_clr", int'(too_fast), 0);
        burst(5, 12'h7FF, 8'hFF, 12'h800, 1'b0, 2047, 2047);
        drain();
        chk("too_fast_set2", int'(too_fast), 1);
        pwr_pulse();

        // Async reset with the fast counter part-way up.
        burst(3, 12'h7FF, 8'hFF, 12'h800, 1'b0, 2047, 2047);
        drain();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_lft", int'($signed(lft_spd)), 0);
        chk("arst_rght", int'($signed(rght_spd)), 0);
        chk("arst_vld_out", int'(vld_out), 0);
        chk("arst_too_fast", int'(too_fast), 0);
        m_l = 0;
        m_r = 0;
        m_cnt = 0;
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send_lat(12'h7FF, 8'hFF, 12'h800, 1'b0, 2047, 2047);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/segway_math_slew.md
Name: segway_math_slew

Overview:
Parametrised next-generation torque math block for the Segway drive path. Takes the PID command, soft-start timer and steering pot, and produces per-wheel signed speed commands. Compared with the previous generation it adds a generic datapath width, a valid-qualified 3-stage pipeline, wide saturating shaping arithmetic, a per-wheel slew-rate limiter, and a debounced too_fast flag. It sits between the PID block and the motor PWM/drive blocks.

Parameters:
W, 12, datapath/command width; outputs are signed W bits
MIN_DUTY, 13'h3C0, dead-zone offset added to |torque| above band (W+1 bits)
LOW_TORQUE_BAND, 8'h3C, |torque| at or below this uses gain shaping
GAIN_MULT, 6'h10, low-band gain multiplier
SLEW_MAX, 12'h040, max output change per valid sample (unsigned, nonzero)
FAST_THRESH, 1792, signed too_fast threshold
FAST_CNT, 4, consecutive over-threshold valid samples needed to raise too_fast (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
vld_in  in  1  input sample valid, one cycle per sample
PID_cntrl  in  W  signed PID command
ss_tmr  in  8  unsigned soft-start scale
steer_pot  in  W  unsigned steering pot reading
en_steer  in  1  steering enable
pwr_up  in  1  drive enable; low forces zero output
vld_out  out  1  output update strobe
lft_spd  out  W  signed left speed command
rght_spd  out  W  signed right speed command
too_fast  out  1  debounced overspeed flag

Behaviour:
- Reset (rst_n low, async): all pipe valids 0, vld_out=0, lft_spd=rght_spd=0, too_fast=0, fast counter 0.
- Pipeline: valid bit shifts every clk; each stage data register loads only when its incoming valid is 1, else holds. Latency: vld_in at edge n -> vld_out high for one cycle after edge n+3, outputs updated at the same edge. Back-to-back samples accepted every cycle; no stall.
- S1: PID_ss = (PID_cntrl * signed{0,ss_tmr}) >>> 8, kept as W+1 bits signed. steer clipped to [2^(W-3), 7*2^(W-3)] (0x200..0xE00 at W=12); steer_term = ((clip - (2^(W-1)-1)) >>> 4) * 3, signed.
- S2: lft_t = PID_ss + steer_term, rght_t = PID_ss - steer_term if en_steer, else both = PID_ss; W+2 bits, no wrap.
- S3: per wheel: |t| > LOW_TORQUE_BAND -> t +/- MIN_DUTY (sign of t); else t*GAIN_MULT; computed at W+8 bits, then saturated to [-2^(W-1), 2^(W-1)-1] = target. pwr_up low in S3 -> target 0.
- Output stage (per wheel, on valid): if |target-cur| <= SLEW_MAX then cur=target, else cur += sign*SLEW_MAX. Difference computed at W+1 bits.
- too_fast: on each valid output update, if either target > FAST_THRESH, counter increments (saturating at FAST_CNT), else counter=0 and too_fast=0 at that edge. too_fast=1 when counter reaches FAST_CNT. Uses pre-slew target.
- pwr_up low (any cycle, synchronous): at next edge all pipe valids cleared, lft_spd=rght_spd=0 immediately (slew bypassed), counter=0, too_fast=0, vld_out=0. Samples in flight are discarded.
- Simultaneous vld_in and pwr_up low: sample dropped.
- Async reset mid-operation: state returns to reset values at once; first valid after release produces an output 3 cycles later.

Optional Feature:
SEGWAY_MATH_SLEW_EN: defined -> slew limiter active as above. Undefined -> output stage loads target directly (cur=target); latency, vld_out timing and too_fast unchanged; SLEW_MAX ignored.

Decomposition:
- Package segway_math_pkg: default constants (MIN_DUTY, band, gain, thresholds), a signed saturate function (width-generic via parameterised width arg), and a steer clip-bound constant function.
- One sub-module segway_slew_lim (current register, target in, valid, clear, step): instantiated per wheel.

Test Plan:
- PID=0x100, ss_tmr=0xFF, en_steer=0, pwr_up=1, single vld_in -> vld_out 3 cycles later; target 0x4BF; slew on: lft_spd=rght_spd=0x040 after 1st sample, 0x4BF after the 19th consecutive sample; slew off: 0x4BF at once.
- PID=0x020, ss_tmr=0xFF -> PID_ss=0x1F, low band, target 0x1F0 both wheels.
- PID=0, steer_pot=0xFFF, en_steer=1 -> steer_term=0x120; lft target 0x4E0, rght target 0xB20 (-1248); en_steer=0 -> both 0.
- PID=0x7FF, ss_tmr=0xFF, repeated vld_in -> target saturates 0x7FF; too_fast rises on the 4th valid output, falls on the first valid sample with PID=0.
- Steady at 0x4BF, then pwr_up low for one cycle -> next edge lft_spd=rght_spd=0, too_fast=0, in-flight vld_in produce no vld_out.
- Assert rst_n low mid-ramp -> outputs/flags 0 immediately without a clock edge; resume -> correct 3-cycle latency.
